// File: rtl/sram_cache.sv
// sram_cache: two-way set-associative write-through, no-write-allocate data cache in front of the SRAM controller
module sram_cache #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          SETS      = 64,
    parameter int          TAG_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    localparam logic [1:0] IDLE = 2'd0, RD_MISS = 2'd1, WRITE = 2'd2;
    logic [1:0]       state, state_nx;
    logic [SETS-1:0]  valid0, valid1, lru;
    logic [TAG_W-1:0] tag0 [SETS];
    logic [TAG_W-1:0] tag1 [SETS];
    logic [63:0]      data0 [SETS];
    logic [63:0]      data1 [SETS];
    logic [31:0]      off;
    logic [5:0]       idx;
    logic [TAG_W-1:0] tg;
    logic             ws, hit0, hit1, hit, hit_way, victim, rd_hit, fill, upd;
    logic [63:0]      hit_blk;
    logic             unused_bits;
    assign off         = address - BASE_ADDR;
    assign ws          = off[2];
    assign idx         = off[8:3];
    assign tg          = off[9 +: TAG_W];
    assign unused_bits = ^{off[31:19], off[1:0]};
    assign hit0    = valid0[idx] && tag0[idx] == tg;
    assign hit1    = valid1[idx] && tag1[idx] == tg;
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    assign hit_blk = hit1 ? data1[idx] : data0[idx];
    assign victim  = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
    assign rd_hit  = state == IDLE && rd_en && !wr_en && hit;
    assign fill    = state == RD_MISS && sram_ready;
    assign upd     = state == WRITE && sram_ready && hit;
    // Enables depend on registered state only, so they never glitch with the CPU request
    assign sram_rd_en   = state == RD_MISS;
    assign sram_wr_en   = state == WRITE;
    assign sram_address = address;
    assign sram_wdata   = wdata;
    always_comb begin
        ready    = state == IDLE ? !(wr_en || (rd_en && !hit)) : sram_ready;
        rdata    = fill   ? (ws ? sram_rdata[63:32] : sram_rdata[31:0]) :
                   rd_hit ? (ws ? hit_blk[63:32] : hit_blk[31:0]) : 32'd0;
        state_nx = state == IDLE ? (wr_en ? WRITE : (rd_en && !hit) ? RD_MISS : IDLE) :
                   sram_ready ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            state <= state_nx;
            if (rd_hit || upd)
                lru[idx] <= ~hit_way;
            if (fill) begin
                if (victim)
                    valid1[idx] <= 1'b1;
                else
                    valid0[idx] <= 1'b1;
                lru[idx] <= ~victim;
            end
        end
    end
    // Tags and data need no reset: they are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (fill && victim) begin
            tag1[idx]  <= tg;
            data1[idx] <= sram_rdata;
        end
        if (fill && !victim) begin
            tag0[idx]  <= tg;
            data0[idx] <= sram_rdata;
        end
        if (upd && hit_way) begin
            if (ws)
                data1[idx][63:32] <= wdata;
            else
                data1[idx][31:0] <= wdata;
        end
        if (upd && !hit_way) begin
            if (ws)
                data0[idx][63:32] <= wdata;
            else
                data0[idx][31:0] <= wdata;
        end
    end
endmodule

// File: tb/tb_sram_cache.sv
// tb_sram_cache: directed vectors for sram_cache with a bench-driven SRAM controller
module tb_sram_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;
    int          n_vec = 0, n_bad = 0;

    sram_cache dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .wdata(wdata), .rdata(rdata), .ready(ready), .sram_rd_en(sram_rd_en),
        .sram_wr_en(sram_wr_en), .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst/ready", ready, 1);
        check("rst/srd", sram_rd_en, 0);
        check("rst/swr", sram_wr_en, 0);
        check("rst/rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Requests at a negedge; a miss/write gets sram_ready in the n-th cycle of the SRAM access
    task automatic xact(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic hit_exp, input logic [63:0] blk,
                        input int n, input logic [31:0] exp_rd);
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; wdata = wd;
        #1;
        if (hit_exp) begin
            check({tag, "/hit_rdy"}, ready, 1);
            check({tag, "/hit_rdata"}, rdata, exp_rd);
            check({tag, "/hit_srd"}, sram_rd_en, 0);
            check({tag, "/hit_swr"}, sram_wr_en, 0);
        end else begin
            check({tag, "/req_rdy"}, ready, 0);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                if (i == n - 1) begin
                    sram_ready = 1'b1;
                    sram_rdata = blk;
                end
                #1;
                check({tag, "/srd"}, sram_rd_en, !wr);
                check({tag, "/swr"}, sram_wr_en, wr);
                check({tag, "/sadr"}, sram_address, a);
                if (wr) check({tag, "/swd"}, sram_wdata, wd);
                check({tag, "/rdy"}, ready, i == n - 1);
                if (!wr && i == n - 1) check({tag, "/rdata"}, rdata, exp_rd);
            end
        end
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
        #1;
        check({tag, "/drop_srd"}, sram_rd_en, 0);
        check({tag, "/drop_swr"}, sram_wr_en, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic hit_exp,
                      input logic [63:0] blk, input logic [31:0] exp_rd);
        xact(tag, 1'b1, 1'b0, a, 32'd0, hit_exp, blk, 5, exp_rd);
    endtask

    initial begin
        do_reset();
        // Cold miss then hit on the other word of the filled block
        rd("t1_miss", 32'h400, 0, 64'h11112222_33334444, 32'h33334444);
        rd("t1_hit", 32'h404, 1, 64'h0, 32'h11112222);
        // Write hit updates word1 only
        xact("t3_wr", 1'b0, 1'b1, 32'h404, 32'hDEADBEEF, 0, 64'h0, 5, 32'h0);
        rd("t3_hit1", 32'h404, 1, 64'h0, 32'hDEADBEEF);
        rd("t3_hit0", 32'h400, 1, 64'h0, 32'h33334444);
        // LRU replacement in set 0
        do_reset();
        rd("t2_a", 32'h400, 0, 64'hA1A1A1A1_A0A0A0A0, 32'hA0A0A0A0);
        rd("t2_b", 32'h600, 0, 64'hB1B1B1B1_B0B0B0B0, 32'hB0B0B0B0);
        rd("t2_a_hit", 32'h400, 1, 64'h0, 32'hA0A0A0A0);
        rd("t2_c", 32'h800, 0, 64'hC1C1C1C1_C0C0C0C0, 32'hC0C0C0C0);
        rd("t2_a_hit2", 32'h404, 1, 64'h0, 32'hA1A1A1A1);
        rd("t2_c_hit", 32'h804, 1, 64'h0, 32'hC1C1C1C1);
        rd("t2_b_miss", 32'h600, 0, 64'hB3B3B3B3_B2B2B2B2, 32'hB2B2B2B2);
        rd("t2_c_hit2", 32'h800, 1, 64'h0, 32'hC0C0C0C0);
        // Write miss does not allocate
        xact("t4_wr", 1'b0, 1'b1, 32'hA00, 32'h12345678, 0, 64'h0, 3, 32'h0);
        rd("t4_miss", 32'hA04, 0, 64'h9ABCDEF0_12345678, 32'h9ABCDEF0);
        // Simultaneous rd/wr is a write and fills nothing
        xact("t6_both", 1'b1, 1'b1, 32'h408, 32'h0BADF00D, 0, 64'h0, 2, 32'h0);
        rd("t6_miss", 32'h408, 0, 64'h55555555_66666666, 32'h66666666);
        // Slow controller, then asynchronous abort
        @(negedge clk);
        rd_en = 1'b1; address = 32'h400;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("t5_wait_srd", sram_rd_en, 1);
            check("t5_wait_rdy", ready, 0);
        end
        #2;
        rst = 1'b0;
        #1;
        check("t5_abort_srd", sram_rd_en, 0);
        check("t5_abort_rdata", rdata, 0);
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd("t5_miss", 32'h400, 0, 64'h77777777_88888888, 32'h88888888);
        rd("t5_hit", 32'h404, 1, 64'h0, 32'h77777777);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
